uart_tx_sched: RTL

//  Round-robin scheduler that shares one UART transmitter (rx_module_send) between NREQ byte requesters.

---
 rtl/uart_tx_sched_if.sv | 25 ++
 rtl/uart_tx_sched.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// Bundle between requesters/receiver and the UART transmit scheduler.
// master = requester/receiver side, slave = scheduler side.
interface uart_tx_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_we;
  logic              busy;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              echo_ovf;

  modport master (
    output req, req_data, rx_data, rx_ready,
    input  ack, tx_data, tx_we, busy, echo_ovf
  );

  modport slave (
    input  req, req_data, rx_data, rx_ready,
    output ack, tx_data, tx_we, busy, echo_ovf
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one busy-less UART transmitter among NREQ byte requesters.
// Define UART_SCHED_ECHO_EN to also echo received bytes with priority over all requesters.
module uart_tx_sched #(
  parameter int NREQ         = 4,
  parameter int FRAME_CYCLES = 164
) (
  input logic            clk,
  input logic            rst,
  uart_tx_sched_if.slave bus
);
  localparam int         IDXW     = $clog2(NREQ);
  localparam logic [7:0] TERM_CNT = 8'(FRAME_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    ACK    = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [IDXW-1:0]  rr_ptr_reg;
  logic [IDXW-1:0]  win_idx_reg;
  logic             win_echo_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_we_reg;
  logic [NREQ-1:0]  ack_reg;
  logic [7:0]       cnt_reg;
  logic             strobe_cnt_reg;
  logic             found;
  logic [IDXW-1:0]  pick;
  logic             grant;
  logic             echo_pend;
  logic [7:0]       echo_buf;
  logic [7:0]       req_byte [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
      assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Scan from rr_ptr upward with an explicit wrap so non power-of-two NREQ never yields a bad index.
  always_comb begin : arbiter
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_reg} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(NREQ)) begin
        sum = sum - (IDXW+1)'(NREQ);
      end
      idx = sum[IDXW-1:0];
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign grant = (state_reg == IDLE) && (echo_pend || found);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (echo_pend || found) state_next = SETUP;
      SETUP:   state_next = STROBE;
      STROBE:  if (strobe_cnt_reg) state_next = WAIT;
      WAIT:    if (cnt_reg == TERM_CNT) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      win_idx_reg    <= '0;
      win_echo_reg   <= 1'b0;
      tx_data_reg    <= 8'd0;
      tx_we_reg      <= 1'b0;
      ack_reg        <= '0;
      cnt_reg        <= 8'd0;
      strobe_cnt_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tx_we_reg      <= (state_next == STROBE);
      strobe_cnt_reg <= (state_reg == STROBE) ? ~strobe_cnt_reg : 1'b0;
      cnt_reg        <= (state_reg == WAIT) ? cnt_reg + 8'd1 : 8'd0;
      ack_reg        <= '0;
      if (state_next == ACK && !win_echo_reg) begin
        ack_reg[win_idx_reg] <= 1'b1;
      end
      // tx_data is captured at grant and held until the next grant.
      if (grant) begin
        win_echo_reg <= echo_pend;
        win_idx_reg  <= pick;
        tx_data_reg  <= echo_pend ? echo_buf : req_byte[pick];
      end
      if (state_reg == ACK && !win_echo_reg) begin
        rr_ptr_reg <= (win_idx_reg == IDXW'(NREQ - 1)) ? '0 : win_idx_reg + 1'b1;
      end
    end
  end

`ifdef UART_SCHED_ECHO_EN
  logic       rx_prev_reg;
  logic       echo_pend_reg;
  logic       echo_ovf_reg;
  logic [7:0] echo_buf_reg;
  logic       rx_edge;
  logic       grant_echo;

  assign rx_edge    = bus.rx_ready & ~rx_prev_reg;
  assign grant_echo = (state_reg == IDLE) && echo_pend_reg;

  // A new receive edge wins over the clear, so a byte arriving at grant time stays pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_prev_reg   <= 1'b0;
      echo_pend_reg <= 1'b0;
      echo_ovf_reg  <= 1'b0;
      echo_buf_reg  <= 8'd0;
    end else begin
      rx_prev_reg <= bus.rx_ready;
      if (rx_edge) begin
        echo_buf_reg  <= bus.rx_data;
        echo_pend_reg <= 1'b1;
        if (echo_pend_reg && !grant_echo) begin
          echo_ovf_reg <= 1'b1;
        end
      end else if (grant_echo) begin
        echo_pend_reg <= 1'b0;
      end
    end
  end

  assign echo_pend    = echo_pend_reg;
  assign echo_buf     = echo_buf_reg;
  assign bus.echo_ovf = echo_ovf_reg;
`else
  logic unused_rx;
  assign unused_rx    = ^{bus.rx_data, bus.rx_ready};
  assign echo_pend    = 1'b0;
  assign echo_buf     = 8'd0;
  assign bus.echo_ovf = 1'b0;
`endif

  assign bus.tx_data = tx_data_reg;
  assign bus.tx_we   = tx_we_reg;
  assign bus.ack     = ack_reg;
  assign bus.busy    = (state_reg != IDLE);
endmodule
